// File: rtl/wram_arb_pkg.sv
// Shared types and window helpers for the WRAM shadow arbiter.
package wram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHD_RD,
        SHD_WR,
        SD_WAIT,
        ACK,
        DONE
    } arb_state_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // One extra bit keeps base + size from wrapping at the top of the map.
    function automatic logic win_hit(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

    function automatic logic [31:0] win_idx(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        return (addr - base) & (size - 32'd1);
    endfunction

endpackage

// File: rtl/wram_shadow_arbiter_if.sv
// Requester-side and SDRAM-side buses of the WRAM shadow arbiter.
interface wram_shadow_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int AW     = 22,
    parameter int DW     = 8
);
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_we;
    logic [NUM_CH*AW-1:0] ch_addr;
    logic [NUM_CH*DW-1:0] ch_din;
    logic [NUM_CH*DW-1:0] ch_dout;
    logic [NUM_CH-1:0]    ch_ack;
    logic                 sd_req;
    logic                 sd_we;
    logic [AW-1:0]        sd_addr;
    logic [DW-1:0]        sd_din;
    logic [DW-1:0]        sd_dout;
    logic                 sd_ack;

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_din,
        output ch_dout, ch_ack,
        output sd_req, sd_we, sd_addr, sd_din,
        input  sd_dout, sd_ack
    );

    modport master (
        output ch_req, ch_we, ch_addr, ch_din,
        input  ch_dout, ch_ack,
        input  sd_req, sd_we, sd_addr, sd_din,
        output sd_dout, sd_ack
    );
endinterface

// File: rtl/wram_shadow_bsram.sv
// Single-port shadow RAM, one-cycle read latency, write-first.
module wram_shadow_bsram #(
    parameter int DEPTH = 8192,
    parameter int DW    = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/wram_shadow_arbiter.sv
// N-channel arbiter: WRAM window served from a BSRAM shadow,
// everything else (and window write-through) goes to SDRAM.
module wram_shadow_arbiter
    import wram_arb_pkg::*;
#(
    parameter int          NUM_CH        = 2,
    parameter int          AW            = 22,
    parameter int          DW            = 8,
    parameter int unsigned WIN_BASE      = 32'h0000_6000,
    parameter int unsigned WIN_SIZE      = 8192,
    parameter int          PRIO_MODE     = PRIO_FIXED,
    parameter int          LOAD_CH       = 1,
    parameter int          WRITE_THROUGH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_override,
    output logic busy,
    wram_shadow_arbiter_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW = $clog2(WIN_SIZE);

    arb_state_t state;
    arb_state_t state_nx;

    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        pick_ch;
    logic [CW-1:0]        g_ch;
    logic                 g_we;
    logic [AW-1:0]        g_addr;
    logic [DW-1:0]        g_din;
    logic [NUM_CH-1:0]    hit_v;
    logic [NUM_CH-1:0]    elig;
    logic [NUM_CH-1:0]    ack_v;
    logic [NUM_CH*DW-1:0] dout_q;
    logic                 grant;
    logic                 w_we;
    logic                 w_hit;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_din;
    logic                 ram_en;
    logic                 ram_we;
    logic [IW-1:0]        ram_addr;
    logic [DW-1:0]        ram_rdata;
    logic                 cap;
    logic [DW-1:0]        cap_data;

    // Override short-circuits the normal order when the loader asks.
    function automatic logic [CW-1:0] pick(
        input logic [NUM_CH-1:0] e,
        input logic [CW-1:0]     ptr,
        input logic              ovr
    );
        logic [CW-1:0] w;
        int best;
        int d;
        w    = '0;
        best = NUM_CH;
        for (int j = 0; j < NUM_CH; j++) begin
            if (e[j]) begin
                if (PRIO_MODE == PRIO_RR)
                    d = (j + NUM_CH - 1 - int'(ptr)) % NUM_CH;
                else
                    d = j;
                if (d < best) begin
                    best = d;
                    w    = CW'(j);
                end
            end
        end
        if (ovr && e[LOAD_CH])
            w = CW'(LOAD_CH);
        return w;
    endfunction

    always_comb begin
        hit_v = '0;
        elig  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit_v[i] = win_hit(32'(bus.ch_addr[i*AW +: AW]),
                               32'(WIN_BASE), 32'(WIN_SIZE));
            // Other channels' window writes wait out a WRAM load.
            elig[i]  = bus.ch_req[i] & ~(load_override & bus.ch_we[i]
                       & hit_v[i] & (i != LOAD_CH));
        end
    end

    assign pick_ch = pick(elig, rr_ptr, load_override);
    assign grant   = (state == IDLE) && (|elig);

    always_comb begin
        w_we   = 1'b0;
        w_hit  = 1'b0;
        w_addr = '0;
        w_din  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (pick_ch == CW'(j)) begin
                w_we   = bus.ch_we[j];
                w_hit  = hit_v[j];
                w_addr = bus.ch_addr[j*AW +: AW];
                w_din  = bus.ch_din[j*DW +: DW];
            end
        end
    end

    assign ram_en   = grant & w_hit;
    assign ram_we   = ram_en & w_we;
    assign ram_addr = IW'(win_idx(32'(w_addr), 32'(WIN_BASE),
                                  32'(WIN_SIZE)));

    wram_shadow_bsram #(
        .DEPTH(WIN_SIZE),
        .DW   (DW),
        .IW   (IW)
    ) u_bsram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(w_din),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (!w_hit)    state_nx = SD_WAIT;
                    else if (w_we) state_nx = SHD_WR;
                    else           state_nx = SHD_RD;
                end
            end
            SHD_RD:  state_nx = ACK;
            SHD_WR:  state_nx = (WRITE_THROUGH != 0) ? SD_WAIT : ACK;
            SD_WAIT: if (bus.sd_ack) state_nx = ACK;
            ACK:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            g_ch   <= '0;
            g_we   <= 1'b0;
            g_addr <= '0;
            g_din  <= '0;
        end else if (grant) begin
            rr_ptr <= pick_ch;
            g_ch   <= pick_ch;
            g_we   <= w_we;
            g_addr <= w_addr;
            g_din  <= w_din;
        end
    end

    assign cap = (state == SHD_RD) ||
                 ((state == SD_WAIT) && bus.sd_ack && !g_we);
    assign cap_data = (state == SHD_RD) ? ram_rdata : bus.sd_dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else if (cap) begin
            for (int j = 0; j < NUM_CH; j++)
                if (g_ch == CW'(j))
                    dout_q[j*DW +: DW] <= cap_data;
        end
    end

    always_comb begin
        ack_v = '0;
        for (int j = 0; j < NUM_CH; j++)
            ack_v[j] = (state == ACK) && (g_ch == CW'(j));
    end

    assign busy        = (state != IDLE);
    assign bus.ch_ack  = ack_v;
    assign bus.ch_dout = dout_q;
    assign bus.sd_req  = (state == SD_WAIT);
    assign bus.sd_we   = bus.sd_req & g_we;
    assign bus.sd_addr = bus.sd_req ? g_addr : '0;
    assign bus.sd_din  = bus.sd_req ? g_din : '0;
endmodule
